// File: rtl/div_sequencer.sv
// RV32M divide-group sequencer: radix-2 restoring divider with RISC-V sign and
// special-case handling, stalling the pipeline until the one-cycle done pulse.
module div_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(XLEN - 1);

    state_t            state_q, state_n;
    logic              is_rem_q, is_rem_n;
    logic              neg_q_q, neg_q_n;
    logic              neg_r_q, neg_r_n;
    logic [XLEN-1:0]   div_q, div_n;
    logic [XLEN-1:0]   quo_q, quo_n;
    logic [XLEN-1:0]   rem_q, rem_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [XLEN-1:0]   result_q, result_n;

    // Operand conditioning for signed ops
    logic              is_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     shifted, diff;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & src_a[XLEN-1];
    assign b_neg     = is_signed & src_b[XLEN-1];
    assign a_mag     = a_neg ? (~src_a + XLEN'(1)) : src_a;
    assign b_mag     = b_neg ? (~src_b + XLEN'(1)) : src_b;

    // One restoring step: shift in the next dividend bit and trial-subtract
    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign diff      = shifted - {1'b0, div_q};

    assign quo_fix   = neg_q_q ? (~quo_q + XLEN'(1)) : quo_q;
    assign rem_fix   = neg_r_q ? (~rem_q + XLEN'(1)) : rem_q;

    always_comb begin
        state_n  = state_q;
        is_rem_n = is_rem_q;
        neg_q_n  = neg_q_q;
        neg_r_n  = neg_r_q;
        div_n    = div_q;
        quo_n    = quo_q;
        rem_n    = rem_q;
        cnt_n    = cnt_q;
        result_n = result_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    is_rem_n = op[1];
                    neg_q_n  = a_neg ^ b_neg;
                    neg_r_n  = a_neg;
                    div_n    = b_mag;
                    quo_n    = a_mag;
                    rem_n    = '0;
                    cnt_n    = '0;
                    if (src_b == '0) begin
                        result_n = op[1] ? src_a : ALL_ONES;
                        state_n  = DONE;
                    end else if (is_signed && src_a == MIN_INT && src_b == ALL_ONES) begin
                        result_n = op[1] ? '0 : MIN_INT;
                        state_n  = DONE;
                    end else begin
                        state_n  = CALC;
                    end
                end
            end
            CALC: begin
                if (!diff[XLEN]) begin
                    rem_n = diff[XLEN-1:0];
                    quo_n = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_n = shifted[XLEN-1:0];
                    quo_n = {quo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == LAST_IT) begin
                    state_n = FIX;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                result_n = is_rem_q ? rem_fix : quo_fix;
                state_n  = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Redirect kills whatever is in flight and leaves the last result intact
        if (flush) begin
            state_n  = IDLE;
            result_n = result_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_n;
            is_rem_q <= is_rem_n;
            neg_q_q  <= neg_q_n;
            neg_r_q  <= neg_r_n;
            div_q    <= div_n;
            quo_q    <= quo_n;
            rem_q    <= rem_n;
            cnt_q    <= cnt_n;
            result_q <= result_n;
        end
    end

    // Stall covers the accept cycle through FIX so the pipeline advances on done
    assign stall_req = ~flush & (((state_q == IDLE) & start) | (state_q == CALC) | (state_q == FIX));
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) & ~flush;
    assign result    = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, stall window, sign rules,
// special cases, flush and mid-operation reset.
module tb_div_sequencer;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int vectors    = 0;
    int miscompares = 0;

    div_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold start from cycle 0 until done; leaves start high so a following call is back-to-back
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, input int lat);
        int cyc;
        int done_cyc;
        logic stall_ok;
        cyc      = 0;
        done_cyc = -1;
        stall_ok = 1'b1;
        tick();
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        while (cyc < 100) begin
            #1;
            if (stall_req !== (cyc < lat)) stall_ok = 1'b0;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            tick();
            cyc++;
            // Operands must be don't-care after the accept cycle
            src_a = ~a;
            src_b = 32'h0000_0001;
            op    = ~o;
        end
        chk({tag, " done_cycle"}, 32'(done_cyc), 32'(lat));
        chk({tag, " result"}, result, expv);
        chk({tag, " stall_window"}, {31'd0, stall_ok}, 32'd1);
        op    = o;
        src_a = a;
        src_b = b;
    endtask

    initial begin
        int cyc;
        logic saw_done;

        rstn  = 1'b0;
        start = 1'b0;
        op    = OP_DIVU;
        src_a = '0;
        src_b = '0;
        flush = 1'b0;
        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset stall", {31'd0, stall_req}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        tick();
        rstn = 1'b1;

        // Normal and signed ops, issued back-to-back
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_op("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run_op("divu big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        run_op("remu big", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);

        // Special cases
        run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem 5/0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        tick();
        start = 1'b0;
        #1;
        chk("idle busy", {31'd0, busy}, 32'd0);
        chk("result hold", result, 32'd0);

        // Flush at cycle 10 of a DIVU
        tick();
        start = 1'b1;
        op    = OP_DIVU;
        src_a = 32'd1000;
        src_b = 32'd3;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        start = 1'b0;
        #1;
        chk("flush stall", {31'd0, stall_req}, 32'd0);
        chk("flush done", {31'd0, done}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush idle", {31'd0, busy}, 32'd0);
        saw_done = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        chk("flush no done", {31'd0, saw_done}, 32'd0);
        chk("flush result kept", result, 32'd0);
        run_op("divu 9/3 post flush", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);
        tick();
        start = 1'b0;

        // Reset pulsed at cycle 20 mid-CALC
        tick();
        start = 1'b1;
        op    = OP_REMU;
        src_a = 32'd1234;
        src_b = 32'd10;
        for (int i = 0; i < 20; i++) tick();
        start = 1'b0;
        rstn  = 1'b0;
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst stall", {31'd0, stall_req}, 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        tick();
        rstn = 1'b1;
        run_op("remu 1234/10 post rst", OP_REMU, 32'd1234, 32'd10, 32'd4, 34);
        tick();
        start = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller and iterative datapath for the RV32M divide group (DIV/DIVU/REM/REMU) in the EX stage of the 5-stage pipeline.
- Accepts an operation from EX, runs a radix-2 restoring division over XLEN iterations and applies RISC-V sign and special-case rules.
- While it runs, it requests a pipeline stall; the hazard unit ORs `stall_req` into `pc_en`/`if_id_en` hold and `id_ex` bubble insertion.
- Returns the result for EX→MEM in a single `done` cycle.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 5, iteration counter width; must equal clog2(XLEN).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  level; EX holds a divide-group instruction (opcode 0110011, funct7 0000001, funct3[2]=1).
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- src_a  input  XLEN  dividend (rs1 after forwarding).
- src_b  input  XLEN  divisor (rs2 after forwarding).
- flush  input  1  kill in-flight operation (branch/jump redirect clearing EX).
- stall_req  output  1  hold PC and IF/ID, hold ID/EX, bubble into EX/MEM.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  quotient or remainder per op.

Behaviour:
- Reset (rstn=0, async): state=IDLE, counter=0, all internal registers=0, stall_req=0, busy=0, done=0, result=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start=1 and flush=0, latch op, src_a, src_b.
  - Signed ops (DIV/REM) take absolute values and record neg_q = sign(a) XOR sign(b) and neg_r = sign(a).
  - If src_b==0 → DONE with quotient=all ones and remainder=src_a.
  - Else if signed and src_a=0x80000000 and src_b=0xFFFFFFFF → DONE with quotient=0x80000000 and remainder=0.
  - Otherwise → CALC with counter=0 and partial remainder=0.
- CALC, one iteration per cycle:
  - Shift {rem, quo} left 1.
  - Trial-subtract the divisor from rem (XLEN+1-bit subtract).
  - If the result is non-negative, keep the difference and set quo LSB=1.
  - After iteration XLEN-1 (counter==XLEN-1) → FIX; otherwise counter+1.
- FIX: negate quotient if neg_q, negate remainder if neg_r (signed ops only); → DONE.
- DONE: done=1; result = quotient (op[1]=0) or remainder (op[1]=1); → IDLE unconditionally. start is ignored in DONE because the same instruction is still in EX.
- result holds its value after DONE until the next DONE; it is valid only when done=1.
- stall_req (combinational) = (IDLE & start & ~flush) | CALC | FIX. It is 0 in DONE, so the pipeline advances with the result that cycle.
- busy = state != IDLE.
- Latency, start cycle counted as cycle 0:
  - Normal: done at cycle XLEN+2 = 34; stall_req high for cycles 0..33.
  - Special cases: done at cycle 1, stall_req high for cycle 0 only.
- flush in any state → IDLE on the next edge; no done pulse; stall_req forced 0 in the flush cycle; result unchanged.
- flush and start in the same IDLE cycle: start ignored.
- Back-to-back divides: the second start is seen in the IDLE cycle after DONE and is accepted normally.
- rstn asserted mid-operation: immediate return to reset values; no done.
- op/src_a/src_b may change after the accept cycle without effect.

Test Plan:
- DIVU 100/7, start held → stall_req=1 for cycles 0..33, done at cycle 34, result=14; REMU same operands → result=2.
- DIV -7/2 (0xFFFFFFF9, 2) → result=0xFFFFFFFD (-3); REM → result=0xFFFFFFFF (-1).
- Divide by zero: DIVU 5/0 → done at cycle 1, result=0xFFFFFFFF; REM 5/0 → result=5.
- Overflow: DIV 0x80000000/0xFFFFFFFF → result=0x80000000 at cycle 1; REM → result=0.
- flush at cycle 10 of DIVU → state IDLE at cycle 11, no done pulse, stall_req=0 from cycle 10; new DIVU 9/3 then gives result=3 at cycle 34 after its own start.
- rstn pulsed low at cycle 20 mid-CALC → busy=0, stall_req=0, result=0 immediately; start held after release gives a normal full-latency result.
